// File: rtl/demux_1_to_4_stream.sv
// Registered 1-to-4 stream demultiplexer with a one-entry slice per output port.
// Optional build macro DEMUX_1_TO_4_STREAM_DROP_EN: never backpressure, drop words to full ports.
module demux_1_to_4_stream #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_sel,
    input  logic [N-1:0] in_data,
    output logic [N-1:0] out00,
    output logic [N-1:0] out01,
    output logic [N-1:0] out10,
    output logic [N-1:0] out11,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic [7:0]   drop_count
);

    logic         slot_free_s;
    logic         load_s;
    logic [3:0]   valid_q;
    logic [3:0]   valid_d;
    logic [N-1:0] data_q [4];
    logic [N-1:0] data_d [4];

    // Selected slice can take a word when empty or being drained this same cycle.
    always_comb begin
        slot_free_s = !valid_q[in_sel] || out_ready[in_sel];
        load_s      = in_valid && slot_free_s;
    end

`ifdef DEMUX_1_TO_4_STREAM_DROP_EN
    assign in_ready = 1'b1;
`else
    assign in_ready = slot_free_s;
`endif

    // Next state per slice: reload on a new word, otherwise empty once consumed.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (load_s && (in_sel == 2'(i))) begin
                valid_d[i] = 1'b1;
                data_d[i]  = in_data;
            end else begin
                valid_d[i] = valid_q[i] && !out_ready[i];
                data_d[i]  = data_q[i];
            end
        end
    end

    // Slice registers; data is kept while invalid to avoid needless toggling.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            valid_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= {N{1'b0}};
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_valid = valid_q;
    assign out00     = data_q[0];
    assign out01     = data_q[1];
    assign out10     = data_q[2];
    assign out11     = data_q[3];

`ifdef DEMUX_1_TO_4_STREAM_DROP_EN
    logic [7:0] drop_q;
    logic [7:0] drop_d;

    // Count words discarded at a full, stalled port; saturates instead of wrapping.
    always_comb begin
        if (in_valid && !slot_free_s && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // Drop counter register, cleared only by reset.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            drop_q <= 8'd0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_demux_1_to_4_stream.sv
// Self-checking bench for demux_1_to_4_stream: directed scenarios plus randomized traffic
// compared against a per-port queue model of the demultiplexer.
module tb_demux_1_to_4_stream;

`ifdef DEMUX_1_TO_4_STREAM_DROP_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic        clk;
    logic        rstb;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [31:0] in_data;
    logic [31:0] out00, out01, out10, out11;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [7:0]  drop_count;

    logic [31:0] outs [4];
    assign outs[0] = out00;
    assign outs[1] = out01;
    assign outs[2] = out10;
    assign outs[3] = out11;

    int nvec = 0;
    int nerr = 0;

    // Reference model: each port is a FIFO of depth one, plus a saturating drop counter.
    logic [31:0] mq [4][$];
    int          mdrop = 0;

    demux_1_to_4_stream #(.N(32)) dut (
        .clk(clk), .rstb(rstb),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out00(out00), .out01(out01), .out10(out10), .out11(out11),
        .out_valid(out_valid), .out_ready(out_ready), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] model_valid();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (mq[i].size() != 0);
        return v;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 4; i++) mq[i].delete();
        mdrop = 0;
    endfunction

    // Drives one cycle from a negedge, samples in_ready before the edge, advances the model.
    task automatic cycle(input logic v, input logic [1:0] s, input logic [31:0] d,
                         input logic [3:0] ordy, output logic rdy_obs, output logic rdy_exp);
        bit free;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = ordy;
        #1;
        rdy_obs = in_ready;
        free    = (mq[s].size() == 0) || ordy[s];
        rdy_exp = DROP_EN ? 1'b1 : free;
        @(posedge clk);
        for (int i = 0; i < 4; i++)
            if (mq[i].size() != 0 && ordy[i]) void'(mq[i].pop_front());
        if (v && free) mq[s].push_back(d);
        else if (v && DROP_EN && mdrop < 255) mdrop++;
        @(negedge clk);
    endtask

    task automatic drain();
        logic ro, re;
        cycle(1'b0, 2'd0, 32'd0, 4'b1111, ro, re);
    endtask

    task automatic test_reset();
        nvec++;
        if (out_valid !== 4'b0000) begin nerr++; $display("FAIL reset_valid: got %b want 0000", out_valid); end
        nvec++;
        if ({out00, out01, out10, out11} !== 128'd0) begin nerr++; $display("FAIL reset_data: got %h %h %h %h want 0", out00, out01, out10, out11); end
        nvec++;
        if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        nvec++;
        if (drop_count !== 8'd0) begin nerr++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
        rstb = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_routing();
        logic ro, re;
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            w = 32'hA000_0000 + 32'(i);
            cycle(1'b1, 2'(i), w, 4'b1111, ro, re);
            nvec++;
            if (ro !== 1'b1) begin nerr++; $display("FAIL route_ready[%0d]: got %b want 1", i, ro); end
            nvec++;
            if (out_valid !== (4'b0001 << i)) begin nerr++; $display("FAIL route_valid[%0d]: got %b want %b", i, out_valid, 4'b0001 << i); end
            nvec++;
            if (outs[i] !== w) begin nerr++; $display("FAIL route_data[%0d]: got %h want %h", i, outs[i], w); end
        end
        drain();
        nvec++;
        if (out_valid !== 4'b0000) begin nerr++; $display("FAIL route_idle: got %b want 0000", out_valid); end
    endtask

    task automatic test_stall_isolation();
        logic ro, re;
        cycle(1'b1, 2'd0, 32'h11, 4'b1110, ro, re);
        cycle(1'b1, 2'd0, 32'h22, 4'b1110, ro, re);
        nvec++;
        if (ro !== DROP_EN) begin nerr++; $display("FAIL stall_ready: got %b want %b", ro, DROP_EN); end
        cycle(1'b1, 2'd2, 32'h33, 4'b1110, ro, re);
        nvec++;
        if (ro !== 1'b1 || out_valid !== 4'b0101 || out10 !== 32'h33) begin
            nerr++; $display("FAIL stall_other: ready %b valid %b out10 %h want 1 0101 33", ro, out_valid, out10);
        end
        nvec++;
        if (out00 !== 32'h11) begin nerr++; $display("FAIL stall_hold: got %h want 11", out00); end
        cycle(1'b1, 2'd0, 32'h22, 4'b1111, ro, re);
        nvec++;
        if (ro !== 1'b1 || out_valid !== 4'b0001 || out00 !== 32'h22) begin
            nerr++; $display("FAIL stall_order: ready %b valid %b out00 %h want 1 0001 22", ro, out_valid, out00);
        end
        drain();
    endtask

    task automatic test_simultaneous();
        logic ro, re;
        cycle(1'b1, 2'd1, 32'h55, 4'b0000, ro, re);
        nvec++;
        if (out_valid !== 4'b0010 || out01 !== 32'h55) begin nerr++; $display("FAIL simul_load: valid %b out01 %h want 0010 55", out_valid, out01); end
        cycle(1'b1, 2'd1, 32'h66, 4'b0010, ro, re);
        nvec++;
        if (ro !== 1'b1) begin nerr++; $display("FAIL simul_ready: got %b want 1", ro); end
        nvec++;
        if (out_valid !== 4'b0010 || out01 !== 32'h66) begin nerr++; $display("FAIL simul_reload: valid %b out01 %h want 0010 66", out_valid, out01); end
        drain();
    endtask

    task automatic test_random();
        logic ro, re;
        logic v, hold;
        logic [1:0] s;
        logic [31:0] d;
        hold = 1'b0;
        s = 2'd0;
        d = 32'd0;
        for (int k = 0; k < 400; k++) begin
            if (!hold) begin
                v = ($urandom_range(0, 3) != 0);
                s = 2'($urandom_range(0, 3));
                d = $urandom;
            end
            cycle(v, s, d, 4'($urandom_range(0, 15)), ro, re);
            hold = !DROP_EN && v && !ro;
            nvec++;
            if (ro !== re) begin nerr++; $display("FAIL rand_ready@%0d: got %b want %b", k, ro, re); end
            nvec++;
            if (out_valid !== model_valid()) begin nerr++; $display("FAIL rand_valid@%0d: got %b want %b", k, out_valid, model_valid()); end
            for (int i = 0; i < 4; i++) begin
                if (mq[i].size() != 0) begin
                    nvec++;
                    if (outs[i] !== mq[i][0]) begin nerr++; $display("FAIL rand_data@%0d p%0d: got %h want %h", k, i, outs[i], mq[i][0]); end
                end
            end
            nvec++;
            if (drop_count !== 8'(mdrop)) begin nerr++; $display("FAIL rand_drop@%0d: got %0d want %0d", k, drop_count, mdrop); end
        end
        hold = 1'b0;
        drain();
    endtask

    task automatic test_reset_midstream();
        logic ro, re;
        cycle(1'b1, 2'd1, 32'hBEEF_0001, 4'b0000, ro, re);
        cycle(1'b1, 2'd2, 32'hBEEF_0002, 4'b0000, ro, re);
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        out_ready = 4'b0000;
        rstb = 1'b0;
        #1;
        model_clear();
        nvec++;
        if (out_valid !== 4'b0000) begin nerr++; $display("FAIL midrst_valid: got %b want 0000", out_valid); end
        nvec++;
        if (out01 !== 32'd0 || out10 !== 32'd0) begin nerr++; $display("FAIL midrst_data: got %h %h want 0 0", out01, out10); end
        nvec++;
        if (in_ready !== 1'b1) begin nerr++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        rstb = 1'b1;
        @(negedge clk);
        nvec++;
        if (out_valid !== 4'b0000) begin nerr++; $display("FAIL midrst_after: got %b want 0000", out_valid); end
    endtask

    task automatic test_drop();
        logic ro, re;
        int bad;
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            cycle(1'b1, 2'd3, 32'hD000_0000 + 32'(k), 4'b0000, ro, re);
            nvec++;
            if (ro !== ((k == 0) || DROP_EN)) begin
                nerr++;
                if (bad < 5) $display("FAIL drop_ready@%0d: got %b want %b", k, ro, (k == 0) || DROP_EN);
                bad++;
            end
        end
        nvec++;
        if (out_valid !== 4'b1000 || out11 !== 32'hD000_0000) begin nerr++; $display("FAIL drop_hold: valid %b out11 %h want 1000 d0000000", out_valid, out11); end
        nvec++;
        if (drop_count !== (DROP_EN ? 8'd255 : 8'd0)) begin nerr++; $display("FAIL drop_count: got %0d want %0d", drop_count, DROP_EN ? 255 : 0); end
        in_valid = 1'b0;
        drain();
        nvec++;
        if (out_valid !== 4'b0000) begin nerr++; $display("FAIL drop_drain: got %b want 0000", out_valid); end
    endtask

    initial begin
        rstb      = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = 32'd0;
        out_ready = 4'b0000;
        repeat (2) @(negedge clk);
        test_reset();
        test_routing();
        test_stall_isolation();
        test_simultaneous();
        test_random();
        test_reset_midstream();
        test_drop();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
